fwd_ctrl: RTL and testbench

Pipelined forwarding and load-use hazard controller for the 5-stage MIPS core. It tracks the destination register and write/load flags of the instructions in EX, MEM and WB. It produces the 2-bit select codes that drive the `Mux3` operand multiplexers in front of the ALU, and issues a one-cycle load-use stall with a bubble into EX.

---
 rtl/fwd_pkg.sv | 42 ++++
 rtl/fwd_stage_reg.sv | 26 ++
 rtl/fwd_ctrl.sv | 131 +++++++++++++
 tb/tb_fwd_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types, select codes and the forwarding-select helper for the
// forwarding / load-use hazard controller.
package fwd_pkg;

    // Stage records carry register addresses at a fixed width so the record
    // type does not depend on the controller's REG_AW parameter. REG_AW must be
    // no wider than this; narrower addresses are zero-extended on entry.
    localparam int FWD_REC_AW = 8;
    localparam int FWD_REC_W  = FWD_REC_AW + 2;

    // Operand Mux3 select codes; 2'b11 is never driven (Mux3 outputs zero).
    localparam logic [1:0] FWD_SEL_RF  = 2'b00;
    localparam logic [1:0] FWD_SEL_MEM = 2'b01;
    localparam logic [1:0] FWD_SEL_WB  = 2'b10;

    typedef struct packed {
        logic [FWD_REC_AW-1:0] wr_reg;
        logic                  reg_write;
        logic                  mem_read;
    } stage_rec_t;

    // True when the record will write register r; register 0 never counts.
    function automatic logic rec_writes(stage_rec_t rec, logic [FWD_REC_AW-1:0] r);
        return rec.reg_write && (rec.wr_reg == r) && (r != '0);
    endfunction

    // Select for an operand entering EX: the newest producer (EX record,
    // which will sit in MEM next cycle) beats the older one (MEM record).
    function automatic logic [1:0] next_sel(logic uses, logic [FWD_REC_AW-1:0] r,
                                            stage_rec_t ex, stage_rec_t mem);
        logic [1:0] sel;
        sel = FWD_SEL_RF;
        if (uses) begin
            if (rec_writes(ex, r))
                sel = FWD_SEL_MEM;
            else if (rec_writes(mem, r))
                sel = FWD_SEL_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// fwd_stage_reg: one pipeline stage record {wr_reg, reg_write, mem_read}.
// rst and clear empty the record; hold keeps it (pipeline freeze).
module fwd_stage_reg
    import fwd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       clear,
    input  stage_rec_t d,
    output stage_rec_t q
);

    // Reset beats hold; hold beats a bubble so a frozen stage keeps its record.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (hold)
            q <= q;
        else if (clear)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding-select and load-use stall controller for the 5-stage
// MIPS core. Tracks EX/MEM/WB destination records, produces registered Mux3
// selects for the instruction in EX and a combinational one-cycle load-use
// stall with a bubble into EX.
// Optional feature: define FWD_STALL_CNT_EN to build the load-use stall counter;
// otherwise stall_cnt is tied to zero.
//
// Handshake: there is no valid/ready pair here. stall_id/bubble_ex are a
// same-cycle request to the datapath: while high, PC and IF/ID must hold and
// ID/EX must load a NOP; freeze overrides both and holds the whole pipe.
module fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_AW-1:0]      id_wr_reg,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   freeze,
    input  logic                   flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   stall_id,
    output logic                   bubble_ex,
    output logic [31:0]            stall_cnt,
    output logic [3*FWD_REC_W-1:0] dbg_stages
);

    logic [FWD_REC_AW-1:0] rs_ext;
    logic [FWD_REC_AW-1:0] rt_ext;
    stage_rec_t            id_rec;
    stage_rec_t            ex_rec;
    stage_rec_t            mem_rec;
    stage_rec_t            wb_rec;
    logic                  rs_hit;
    logic                  rt_hit;
    logic                  load_use;
    logic                  bubble_in;

    // Zero-extend ID addresses into the record width.
    always_comb begin
        rs_ext           = FWD_REC_AW'(id_rs);
        rt_ext           = FWD_REC_AW'(id_rt);
        id_rec           = '0;
        id_rec.wr_reg    = FWD_REC_AW'(id_wr_reg);
        id_rec.reg_write = id_reg_write;
        id_rec.mem_read  = id_mem_read;
    end

    // Load-use detection against the load currently in EX; flush wins over it.
    always_comb begin
        rs_hit    = id_uses_rs && (rs_ext == ex_rec.wr_reg);
        rt_hit    = id_uses_rt && (rt_ext == ex_rec.wr_reg);
        load_use  = id_valid && !flush && ex_rec.mem_read && ex_rec.reg_write &&
                    (ex_rec.wr_reg != '0) && (rs_hit || rt_hit);
        bubble_in = !id_valid || flush || load_use;
        // Freeze and reset both suppress the stall request.
        stall_id  = load_use && !freeze && !rst;
        bubble_ex = stall_id;
    end

    fwd_stage_reg u_ex (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .clear (bubble_in),
        .d     (id_rec),
        .q     (ex_rec)
    );

    fwd_stage_reg u_mem (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .clear (1'b0),
        .d     (ex_rec),
        .q     (mem_rec)
    );

    fwd_stage_reg u_wb (
        .clk   (clk),
        .rst   (rst),
        .hold  (freeze),
        .clear (1'b0),
        .d     (mem_rec),
        .q     (wb_rec)
    );

    assign dbg_stages = {ex_rec, mem_rec, wb_rec};

    // Selects are computed as the ID instruction advances so they are stable
    // for the whole cycle it spends in EX; a bubble gets register-file selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_sel <= FWD_SEL_RF;
            fwd_b_sel <= FWD_SEL_RF;
        end else if (!freeze) begin
            if (bubble_in) begin
                fwd_a_sel <= FWD_SEL_RF;
                fwd_b_sel <= FWD_SEL_RF;
            end else begin
                fwd_a_sel <= next_sel(id_uses_rs, rs_ext, ex_rec, mem_rec);
                fwd_b_sel <= next_sel(id_uses_rt, rt_ext, ex_rec, mem_rec);
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] cnt_q;

    // Count issued stall cycles; stall_id is already low when frozen or in reset.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (stall_id)
            cnt_q <= cnt_q + 32'd1;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed scenarios for the forwarding / load-use controller.
module tb_fwd_ctrl;
    import fwd_pkg::*;

    localparam int REG_AW = 5;

    logic                   clk;
    logic                   rst;
    logic                   id_valid;
    logic [REG_AW-1:0]      id_rs;
    logic [REG_AW-1:0]      id_rt;
    logic                   id_uses_rs;
    logic                   id_uses_rt;
    logic [REG_AW-1:0]      id_wr_reg;
    logic                   id_reg_write;
    logic                   id_mem_read;
    logic                   freeze;
    logic                   flush;
    logic [1:0]             fwd_a_sel;
    logic [1:0]             fwd_b_sel;
    logic                   stall_id;
    logic                   bubble_ex;
    logic [31:0]            stall_cnt;
    logic [3*FWD_REC_W-1:0] dbg_stages;

    int          total_cnt;
    int          pass_cnt;
    logic [31:0] exp_cnt;

    fwd_ctrl #(.REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_wr_reg    (id_wr_reg),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .freeze       (freeze),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .stall_cnt    (stall_cnt),
        .dbg_stages   (dbg_stages)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in ID: rs, rt, uses_rs, uses_rt, wr, reg_write, mem_read.
    task automatic drive(input int rs, input int rt, input logic urs, input logic urt,
                         input int wr, input logic rw, input logic mr);
        id_valid     = 1'b1;
        id_rs        = REG_AW'(rs);
        id_rt        = REG_AW'(rt);
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_wr_reg    = REG_AW'(wr);
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic nop();
        id_valid     = 1'b0;
        id_rs        = '0;
        id_rt        = '0;
        id_uses_rs   = 1'b0;
        id_uses_rt   = 1'b0;
        id_wr_reg    = '0;
        id_reg_write = 1'b0;
        id_mem_read  = 1'b0;
        #1;
    endtask

    // Two empty cycles so no earlier producer is left in EX or MEM.
    task automatic drain();
        nop();
        step();
        step();
    endtask

    // Expected counter bump for one issued stall cycle.
    task automatic expect_stall_cycle();
`ifdef FWD_STALL_CNT_EN
        exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        nop();
        step();
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
            $display("FAIL reset_sel: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;
        total_cnt++;
        if (stall_id !== 1'b0 || bubble_ex !== 1'b0 || stall_cnt !== 32'd0)
            $display("FAIL reset_ctl: stall=%b bubble=%b cnt=%0d expected 0 0 0",
                     stall_id, bubble_ex, stall_cnt);
        else pass_cnt++;
        rst = 1'b0;
        #1;
    endtask

    // add $3,$1,$2 ; sub $4,$3,$5 -> a=01, b=00
    task automatic test_back_to_back();
        drain();
        drive(1, 2, 1, 1, 3, 1, 0);
        step();
        drive(3, 5, 1, 1, 4, 1, 0);
        total_cnt++;
        if (stall_id !== 1'b0)
            $display("FAIL b2b_nostall: stall=%b expected 0", stall_id);
        else pass_cnt++;
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00)
            $display("FAIL b2b_sel: a=%b b=%b expected 01 00", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;
    endtask

    // add $3 ; nop ; or $6,$5,$3 -> b=10 ; and the same with $0 as producer
    task automatic test_wb_fwd_and_r0();
        drain();
        drive(1, 2, 1, 1, 3, 1, 0);
        step();
        nop();
        step();
        drive(5, 3, 1, 1, 6, 1, 0);
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10)
            $display("FAIL wb_sel: a=%b b=%b expected 00 10", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;

        drain();
        drive(1, 2, 1, 1, 0, 1, 0);
        step();
        drive(0, 5, 1, 1, 4, 1, 0);
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
            $display("FAIL r0_b2b_sel: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;

        drain();
        drive(1, 2, 1, 1, 0, 1, 0);
        step();
        nop();
        step();
        drive(5, 0, 1, 1, 6, 1, 0);
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
            $display("FAIL r0_wb_sel: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;
    endtask

    // add $3 ; add $3 ; and $7,$3,$3 -> both 01 (newest producer)
    task automatic test_priority();
        drain();
        drive(1, 2, 1, 1, 3, 1, 0);
        step();
        drive(1, 2, 1, 1, 3, 1, 0);
        step();
        drive(3, 3, 1, 1, 7, 1, 0);
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01)
            $display("FAIL prio_sel: a=%b b=%b expected 01 01", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;
        // Operand with uses_rt low gets 00 even though $3 is in flight.
        drive(1, 2, 1, 1, 3, 1, 0);
        step();
        drive(3, 3, 1, 0, 7, 1, 0);
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00)
            $display("FAIL uses_sel: a=%b b=%b expected 01 00", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;
    endtask

    // lw $8 ; add $9,$8,$8 -> one stall cycle, then both 10
    task automatic test_load_use();
        drain();
        drive(1, 0, 1, 0, 8, 1, 1);
        step();
        drive(8, 8, 1, 1, 9, 1, 0);
        total_cnt++;
        if (stall_id !== 1'b1 || bubble_ex !== 1'b1)
            $display("FAIL lu_stall: stall=%b bubble=%b expected 1 1", stall_id, bubble_ex);
        else pass_cnt++;
        expect_stall_cycle();
        step();
        total_cnt++;
        if (stall_id !== 1'b0 || bubble_ex !== 1'b0 || fwd_a_sel !== 2'b00)
            $display("FAIL lu_release: stall=%b bubble=%b a=%b expected 0 0 00",
                     stall_id, bubble_ex, fwd_a_sel);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== exp_cnt)
            $display("FAIL lu_cnt: cnt=%0d expected %0d", stall_cnt, exp_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10)
            $display("FAIL lu_sel: a=%b b=%b expected 10 10", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;

        // A load into $0 never causes a stall.
        drain();
        drive(1, 0, 1, 0, 0, 1, 1);
        step();
        drive(0, 0, 1, 1, 9, 1, 0);
        total_cnt++;
        if (stall_id !== 1'b0)
            $display("FAIL lu_r0: stall=%b expected 0", stall_id);
        else pass_cnt++;
    endtask

    // Load-use together with flush: no stall, bubble enters EX.
    task automatic test_flush();
        drain();
        drive(1, 0, 1, 0, 8, 1, 1);
        step();
        drive(8, 8, 1, 1, 9, 1, 0);
        flush = 1'b1;
        #1;
        total_cnt++;
        if (stall_id !== 1'b0 || bubble_ex !== 1'b0)
            $display("FAIL flush_stall: stall=%b bubble=%b expected 0 0", stall_id, bubble_ex);
        else pass_cnt++;
        step();
        flush = 1'b0;
        // The squashed add must not appear as a producer of $9.
        drive(9, 9, 1, 1, 10, 1, 0);
        total_cnt++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall_id !== 1'b0)
            $display("FAIL flush_bubble: a=%b b=%b stall=%b expected 00 00 0",
                     fwd_a_sel, fwd_b_sel, stall_id);
        else pass_cnt++;
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00)
            $display("FAIL flush_nofwd: a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        else pass_cnt++;
    endtask

    // Load-use under freeze: no stall, sels hold; stall appears after freeze.
    task automatic test_freeze();
        drain();
        drive(2, 3, 1, 1, 1, 1, 0);
        step();
        drive(1, 0, 1, 0, 8, 1, 1);
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b01)
            $display("FAIL frz_pre: a=%b expected 01", fwd_a_sel);
        else pass_cnt++;
        drive(8, 8, 1, 1, 9, 1, 0);
        freeze = 1'b1;
        #1;
        total_cnt++;
        if (stall_id !== 1'b0 || bubble_ex !== 1'b0)
            $display("FAIL frz_stall: stall=%b bubble=%b expected 0 0", stall_id, bubble_ex);
        else pass_cnt++;
        step();
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00 || stall_id !== 1'b0)
            $display("FAIL frz_hold: a=%b b=%b stall=%b expected 01 00 0",
                     fwd_a_sel, fwd_b_sel, stall_id);
        else pass_cnt++;
        freeze = 1'b0;
        #1;
        total_cnt++;
        if (stall_id !== 1'b1 || bubble_ex !== 1'b1)
            $display("FAIL frz_after: stall=%b bubble=%b expected 1 1", stall_id, bubble_ex);
        else pass_cnt++;
        expect_stall_cycle();
        step();
        step();
        total_cnt++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10 || stall_cnt !== exp_cnt)
            $display("FAIL frz_sel: a=%b b=%b cnt=%0d expected 10 10 %0d",
                     fwd_a_sel, fwd_b_sel, stall_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    // Reset asserted in a stall cycle.
    task automatic test_reset_mid_stall();
        drain();
        drive(2, 3, 1, 1, 1, 1, 0);
        step();
        drive(1, 0, 1, 0, 8, 1, 1);
        step();
        drive(8, 8, 1, 1, 9, 1, 0);
        total_cnt++;
        if (stall_id !== 1'b1)
            $display("FAIL rst_pre: stall=%b expected 1", stall_id);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (stall_id !== 1'b0 || bubble_ex !== 1'b0)
            $display("FAIL rst_drop: stall=%b bubble=%b expected 0 0", stall_id, bubble_ex);
        else pass_cnt++;
        step();
        exp_cnt = 32'd0;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || stall_id !== 1'b0 ||
            stall_cnt !== exp_cnt)
            $display("FAIL rst_post: a=%b b=%b stall=%b cnt=%0d expected 00 00 0 0",
                     fwd_a_sel, fwd_b_sel, stall_id, stall_cnt);
        else pass_cnt++;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        exp_cnt   = 32'd0;
        test_reset();
        test_back_to_back();
        test_wb_fwd_and_r0();
        test_priority();
        test_load_use();
        test_flush();
        test_freeze();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
